// File: rtl/red_barrett_pipe.sv
// Three-stage, multi-lane Barrett reducer: maps double-width products x < Q*Q to x mod Q.
// All stages hold together on output backpressure; ready_o is combinational from ready_i.
module red_barrett_pipe #(
  parameter int unsigned Q     = 3329,
  parameter int unsigned QW    = 12,
  parameter int unsigned LANES = 1,
  parameter int unsigned TAG_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [LANES*2*QW-1:0] product_i,
  input  logic [TAG_W-1:0]      tag_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [LANES*QW-1:0]   result_o,
  output logic [TAG_W-1:0]      tag_o,
  output logic [LANES-1:0]      ovf_o
);

  localparam int unsigned PW  = 2 * QW;
  localparam int unsigned K   = 2 * QW;
  localparam int unsigned PPW = PW + QW + 1;

  localparam logic [PW:0] ONE    = 1;
  localparam logic [PW:0] TWO_K  = ONE << K;
  localparam logic [PW:0] Q_EXT  = (PW + 1)'(Q);
  localparam logic [PW:0] M_FULL = TWO_K / Q_EXT;
  localparam logic [QW:0] M      = M_FULL[QW:0];
  localparam logic [PW:0] QQ     = Q_EXT * Q_EXT;
  localparam logic [QW:0] Q_R    = Q_EXT[QW:0];

  logic stall;
  logic adv;
  logic v1_q, v2_q, v3_q;
  logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;

  // Bubbles are carried, not squeezed out, so every stage moves only when the output is free.
  assign stall   = v3_q && !ready_i;
  assign adv     = !stall;
  assign ready_o = adv;
  assign valid_o = v3_q;
  assign tag_o   = tag3_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      tag1_q <= '0;
      tag2_q <= '0;
      tag3_q <= '0;
    end else if (adv) begin
      v1_q   <= valid_i;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
      tag1_q <= tag_i;
      tag2_q <= tag1_q;
      tag3_q <= tag2_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [PW-1:0]  x_in;
      logic [PPW-1:0] p_d;
      logic           ovf_d;
      logic [QW:0]    t_d;
      logic [PW-1:0]  tq;
      logic [PW-1:0]  r_full;
      logic [QW:0]    r_d;
      logic [QW+1:0]  diff;
      logic [QW-1:0]  res_d;
      logic           lane_unused;

      logic [PW-1:0]  x1_q;
      logic [PPW-1:0] p1_q;
      logic           ovf1_q;
      logic [QW:0]    r2_q;
      logic           ovf2_q;
      logic [QW-1:0]  res3_q;
      logic           ovf3_q;

      assign x_in  = product_i[gi*PW +: PW];
      assign p_d   = PPW'(x_in) * PPW'(M);
      assign ovf_d = ({1'b0, x_in} >= QQ);

      // t*Q never exceeds x, and x - t*Q < 2Q fits QW+1 bits, so the low slice is exact.
      assign t_d    = p1_q[PPW-1:K];
      assign tq     = PW'(t_d) * PW'(Q_R);
      assign r_full = x1_q - tq;
      assign r_d    = r_full[QW:0];

      // Top bit of the widened difference is the borrow, i.e. r < Q.
      assign diff  = {1'b0, r2_q} - {1'b0, Q_R};
      assign res_d = ovf2_q ? '0 : (diff[QW+1] ? r2_q[QW-1:0] : diff[QW-1:0]);

      assign lane_unused = ^{r_full[PW-1:QW+1], diff[QW]};

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          x1_q   <= '0;
          p1_q   <= '0;
          ovf1_q <= 1'b0;
          r2_q   <= '0;
          ovf2_q <= 1'b0;
          res3_q <= '0;
          ovf3_q <= 1'b0;
        end else if (adv) begin
          x1_q   <= x_in;
          p1_q   <= p_d;
          ovf1_q <= ovf_d;
          r2_q   <= r_d;
          ovf2_q <= ovf1_q;
          res3_q <= res_d;
          ovf3_q <= ovf2_q;
        end
      end

      assign result_o[gi*QW +: QW] = res3_q;
      assign ovf_o[gi]             = ovf3_q;
    end
  endgenerate

endmodule

// File: tb/tb_red_barrett_pipe.sv
// Scoreboard bench for red_barrett_pipe: default Kyber instance plus a 4-lane Dilithium instance.
module tb_red_barrett_pipe;

  localparam int PW  = 24;
  localparam int PW4 = 46;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Default instance (Q = 3329)
  logic           rst, valid_i, ready_o, valid_o, ready_i;
  logic [PW-1:0]  product_i;
  logic [7:0]     tag_i, tag_o;
  logic [11:0]    result_o;
  logic [0:0]     ovf_o;

  red_barrett_pipe dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .product_i(product_i), .tag_i(tag_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .tag_o(tag_o), .ovf_o(ovf_o)
  );

  // Four-lane instance (Q = 8380417)
  logic           v4_i, r4_o, v4_o, r4_i;
  logic [4*PW4-1:0] p4_i;
  logic [7:0]     t4_i, t4_o;
  logic [4*23-1:0] res4_o;
  logic [3:0]     ovf4_o;

  red_barrett_pipe #(.Q(8380417), .QW(23), .LANES(4), .TAG_W(8)) dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(v4_i), .ready_o(r4_o),
    .product_i(p4_i), .tag_i(t4_i), .valid_o(v4_o), .ready_i(r4_i),
    .result_o(res4_o), .tag_o(t4_o), .ovf_o(ovf4_o)
  );

  typedef struct {
    logic [91:0] res;
    logic [7:0]  tag;
    logic [3:0]  ovf;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  exp_t sb4[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor for the default instance, including output stability while stalled.
  exp_t       e1;
  bit         held = 1'b0;
  logic [11:0] h_res;
  logic [7:0]  h_tag;
  logic        h_ovf;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_valid", 64'(valid_o), 64'(1));
        chk("stall_result", 64'(result_o), 64'(h_res));
        chk("stall_tag", 64'(tag_o), 64'(h_tag));
        chk("stall_ovf", 64'(ovf_o), 64'(h_ovf));
      end
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: result %0d tag %0d with empty scoreboard", result_o, tag_o);
        end else begin
          e1 = sb.pop_front();
          chk("result", 64'(result_o), 64'(e1.res[11:0]));
          chk("tag", 64'(tag_o), 64'(e1.tag));
          chk("ovf", 64'(ovf_o), 64'(e1.ovf[0]));
          if (e1.lat) chk("latency", 64'(cyc - e1.acc), 64'(3));
          $display("out: result=%0d tag=%0d ovf=%0d", result_o, tag_o, ovf_o);
        end
      end
      held  = valid_o && !ready_i;
      h_res = result_o;
      h_tag = tag_o;
      h_ovf = ovf_o[0];
    end
  end

  // Monitor for the four-lane instance.
  exp_t e4;
  always @(negedge clk) begin
    if (!rst && v4_o && r4_i) begin
      if (sb4.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output4: tag %0d with empty scoreboard", t4_o);
      end else begin
        e4 = sb4.pop_front();
        for (int l = 0; l < 4; l++)
          chk($sformatf("lane%0d_result", l), 64'(res4_o[l*23 +: 23]), 64'(e4.res[l*23 +: 23]));
        chk("tag4", 64'(t4_o), 64'(e4.tag));
        chk("ovf4", 64'(ovf4_o), 64'(e4.ovf));
        chk("latency4", 64'(cyc - e4.acc), 64'(3));
        $display("out4: lanes=%0d,%0d,%0d,%0d tag=%0d", res4_o[0 +: 23], res4_o[23 +: 23],
                 res4_o[46 +: 23], res4_o[69 +: 23], t4_o);
      end
    end
  end

  // Present a beat and wait (bounded) until it is accepted; valid_i stays high afterwards.
  task automatic send(input logic [PW-1:0] x, input logic [7:0] tg, input logic [11:0] er,
                      input bit eo, input bit lat);
    exp_t e;
    valid_i   = 1'b1;
    product_i = x;
    tag_i     = tg;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (ready_o) begin
        e.res = 92'(er);
        e.tag = tg;
        e.ovf = 4'(eo);
        e.acc = cyc;
        e.lat = lat;
        sb.push_back(e);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    n_err++;
    $display("FAIL send_timeout: x=%0d accepted 0, expected 1", x);
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [PW-1:0] dir_x [7] = '{24'd0, 24'd3329, 24'd5000, 24'd11075584,
                               24'd11082240, 24'd11082241, 24'd16777215};
  logic [11:0]   dir_r [7] = '{12'd0, 12'd0, 12'd1671, 12'd1, 12'd3328, 12'd0, 12'd0};
  bit            dir_o [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  int start_cyc;
  logic [PW-1:0] xr;
  exp_t e4s;
  logic [45:0] big;

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; product_i = '0; tag_i = '0;
    v4_i = 1'b0; r4_i = 1'b1; p4_i = '0; t4_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 64'(valid_o), 64'(0));
    chk("reset_result", 64'(result_o), 64'(0));
    chk("reset_tag", 64'(tag_o), 64'(0));
    chk("reset_ovf", 64'(ovf_o), 64'(0));
    chk("reset_valid4", 64'(v4_o), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Isolated single beats, including boundaries and overflow inputs
    for (int i = 0; i < 7; i++) begin
      send(dir_x[i], 8'(8'hA0 + i), dir_r[i], dir_o[i], 1'b1);
      idle(5);
    end

    // Back-to-back streaming, ready_i held high
    start_cyc = cyc;
    for (int i = 0; i < 1000; i++) begin
      xr = 24'($urandom_range(0, 11082240));
      send(xr, 8'(i), 12'(xr % 24'd3329), 1'b0, 1'b1);
    end
    chk("stream_cycles", 64'(cyc - start_cyc), 64'(1000));
    idle(6);

    // Backpressure: three beats fill the pipe, downstream refuses for five cycles
    ready_i = 1'b0;
    send(24'd1234567, 8'h31, 12'd2837, 1'b0, 1'b0);
    send(24'd7000,    8'h32, 12'd342,  1'b0, 1'b0);
    send(24'd16662,   8'h33, 12'd17,   1'b0, 1'b0);
    product_i = 24'd9999;
    tag_i     = 8'h34;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", 64'(ready_o), 64'(0));
      chk("bp_valid", 64'(valid_o), 64'(1));
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    send(24'd9999, 8'h34, 12'd12, 1'b0, 1'b0);
    idle(6);

    // Reset with two beats in flight: neither may appear
    send(24'd5000, 8'h11, 12'd1671, 1'b0, 1'b1);
    send(24'd6000, 8'h22, 12'd2671, 1'b0, 1'b1);
    valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rst_valid", 64'(valid_o), 64'(0));
    @(posedge clk); #1;
    send(24'd4000, 8'h44, 12'd671, 1'b0, 1'b1);
    idle(6);

    // Four independent lanes in one beat
    big = 46'(64'd8380416 * 64'd8380416);
    p4_i = {46'd0, 46'd12345678, 46'd8380417, big};
    t4_i = 8'h77;
    v4_i = 1'b1;
    begin : send4
      for (int w = 0; w < 20; w++) begin
        @(negedge clk);
        if (r4_o) begin
          e4s.res = {23'd0, 23'd3965261, 23'd0, 23'd1};
          e4s.tag = 8'h77;
          e4s.ovf = 4'd0;
          e4s.acc = cyc;
          e4s.lat = 1'b1;
          sb4.push_back(e4s);
          @(posedge clk); #1;
          disable send4;
        end
        @(posedge clk); #1;
      end
      n_cmp++;
      n_err++;
      $display("FAIL send4_timeout: accepted 0, expected 1");
    end
    v4_i = 1'b0;

    for (int w = 0; w < 20 && (sb.size() != 0 || sb4.size() != 0); w++) @(posedge clk);
    chk("drain_pending", 64'(sb.size() + sb4.size()), 64'(0));
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/red_barrett_pipe.md
Name: red_barrett_pipe

Overview:
- Pipelined, multi-lane Barrett modular reducer for lattice-crypto coefficient arithmetic (Kyber by default; Dilithium by parameter).
- Takes LANES double-width products in parallel and returns LANES fully reduced residues in [0, Q).
- Uses a valid/ready handshake and carries a sideband tag alongside the data.
- Sits between the modular multiplier array and the NTT/butterfly datapath.

Parameters:
- Q, 3329: modulus. Odd, > 2.
- QW, 12: residue width. Must satisfy 2^(QW-1) < Q < 2^QW. Use 23 for Q = 8380417.
- LANES, 1: number of parallel reduction lanes, 1..8.
- TAG_W, 8: sideband tag width, ≥ 1.
- Derived localparams, not overridable: PW = 2*QW (product width), K = 2*QW (Barrett shift), M = floor(2^K / Q) (5039 for the defaults).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  input beat valid
- ready_o  out  1  block can accept a beat
- product_i  in  LANES*PW  lane n at bits [n*PW +: PW]
- tag_i  in  TAG_W  sideband, passed through unchanged
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accepts the beat
- result_o  out  LANES*QW  lane n at bits [n*QW +: QW], each < Q
- tag_o  out  TAG_W  tag of the current output beat
- ovf_o  out  LANES  per-lane flag: input was ≥ Q*Q

Behaviour:
- Reset (rst_i high at a rising edge):
  - All stage valid bits, valid_o, result_o, tag_o and ovf_o go to 0.
  - Pipeline data registers go to 0.
  - Beats in flight are discarded. Reset mid-stream drops them silently.
- Handshake:
  - A beat transfers on a clock edge where valid_i && ready_o. The output transfers on valid_o && ready_i.
  - stall = valid_o && !ready_i.
  - ready_o = !stall. This is a combinational path from ready_i to ready_o, documented as such.
  - When stall is high, every stage register holds. Bubbles do not collapse.
  - valid_o, result_o, tag_o and ovf_o stay stable while valid_o && !ready_i.
- Pipeline, 3 register stages. Latency from input accept to valid_o is 3 cycles. Throughput is 1 beat per cycle with no stall.
  - S1: register x (PW bits), the product p = x*M (PW + QW + 1 bits, exact), the tag, and ovf = (x ≥ Q*Q).
  - S2: t = p >> K; r = x - t*Q. r is computed at QW+1 bits. For x < Q*Q, r lies in [0, 2Q).
  - S3 (output registers): result = (r ≥ Q) ? r - Q : r. Implement the comparison as the borrow of a (QW+1)-bit subtraction r - Q.
  - If the ovf bit for a lane is set, that lane's result_o is forced to 0 and ovf_o[n] = 1.
- Lanes are fully independent datapaths and share one valid, ready and tag.
- All arithmetic is unsigned. No intermediate truncation is allowed before the final QW-bit result.
- Boundary behaviour:
  - x = 0 gives 0.
  - x = Q gives 0.
  - x = Q*Q - 1 is the largest legal input.
  - Inputs ≥ Q*Q (including x = 2^PW - 1) give result 0 with ovf set.
  - valid_i may be high while ready_o is low. The beat is simply not taken and must be held by the sender.
  - An accept and an output transfer in the same cycle are both honoured.

Test Plan:
- Defaults, single beats: x ∈ {0, 3329, 5000, 3328*3328 = 11075584} -> result_o {0, 0, 1671, 1}, each 3 cycles after accept; ovf_o = 0.
- Overflow: x = 11082241 (Q*Q) and x = 16777215 -> result_o 0, ovf_o = 1, tag preserved.
- Streaming with ready_i = 1: 1000 random x < Q*Q, tags 0..255 wrapping -> one output per cycle after a 3-cycle fill; results equal x mod 3329; tags in order.
- Backpressure: 3 beats in flight, ready_i low for 5 cycles -> ready_o low; outputs frozen and stable; no loss or duplication; order resumes once ready_i returns to 1.
- Reset mid-stream: rst_i asserted for 1 cycle with 2 beats in flight -> valid_o = 0 the next cycle; in-flight beats never appear; a new beat afterwards gives its correct result 3 cycles after accept.
- LANES = 4, Q = 8380417, QW = 23: per lane, x = {8380416², 8380417, 12345678, 0} -> {1, 0, 3965261, 0}, all in the same beat.
